cacheline_burst_responder: RTL

//   Memory-side responder for the cache's pmem interface. Accepts one-line read/write

---
 rtl/cacheline_burst_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cacheline_burst_responder.sv
// rtl/cacheline_burst_responder.sv - cache-line to narrow-burst memory responder
module cacheline_burst_responder #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   // cache side
   input  logic               read_i,
   input  logic               write_i,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   output logic               resp_o,
   // memory side
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
   input  logic               resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFS_W = $clog2(LINE_W / 8);

   // Clears the byte-offset bits so the memory always sees a line-aligned address.
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD_BURST,
      S_WR_BURST,
      S_DONE
   } state_t;

   state_t                         r_state;
   state_t                         w_next;

   logic [CNT_W-1:0]               r_cnt;
   logic [ADDR_W-1:0]              r_addr;
   logic [BEATS-1:0][BURST_W-1:0]  r_wline;
   logic [BEATS-1:0][BURST_W-1:0]  r_rbuf;
   logic [LINE_W-1:0]              r_line_o;

   logic [BEATS-1:0][BURST_W-1:0]  w_assembled;
   logic [ADDR_W-1:0]              w_aligned;
   logic                           w_last;

   assign w_aligned = address_i & LINE_MASK;
   assign w_last    = (r_cnt == CNT_W'(BEATS - 1));

   assign address_o = r_addr;
   assign line_o    = r_line_o;

   // Full line as it will look once the beat currently on burst_i is stored.
   always_comb begin
      w_assembled          = r_rbuf;
      w_assembled[r_cnt]   = burst_i;
   end

   // State register; an asynchronous reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and memory/cache strobes, all decoded from state and registers.
   always_comb begin
      w_next  = r_state;
      read_o  = 1'b0;
      write_o = 1'b0;
      resp_o  = 1'b0;
      burst_o = '0;
      case (r_state)
         S_IDLE: begin
            if (write_i) begin
               w_next = S_WR_BURST;
            end else if (read_i) begin
               w_next = S_RD_BURST;
            end
         end
         S_RD_BURST: begin
            read_o = 1'b1;
            if (resp_i && w_last) begin
               w_next = S_DONE;
            end
         end
         S_WR_BURST: begin
            write_o = 1'b1;
            burst_o = r_wline[r_cnt];
            if (resp_i && w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            resp_o = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Request latching, beat counting and read-line assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wline  <= '0;
         r_rbuf   <= '0;
         r_line_o <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (write_i) begin
                  r_addr  <= w_aligned;
                  r_wline <= line_i;
               end else if (read_i) begin
                  r_addr  <= w_aligned;
               end
            end
            S_RD_BURST: begin
               if (resp_i) begin
                  r_rbuf[r_cnt] <= burst_i;
                  r_cnt         <= r_cnt + 1'b1;
                  // line_o only changes once a whole line has arrived
                  if (w_last) begin
                     r_line_o <= w_assembled;
                  end
               end
            end
            S_WR_BURST: begin
               if (resp_i) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
